// File: rtl/radix_4_div_pkg.sv
// rtl/radix_4_div_pkg.sv - shared radix-4 SRT divider constants and OTF state type
//
// Purpose: one-hot quotient digit encoding and on-the-fly converter state enum,
//          shared by the quotient-digit-selection logic and the OTF converter.
// Ports:   none (package).

package radix_4_div_pkg;

   localparam int QUOT_ONEHOT_WIDTH = 5;

   // Bit index of each digit inside the one-hot digit vector.
   localparam int QUOT_NEG_2 = 0;
   localparam int QUOT_NEG_1 = 1;
   localparam int QUOT_ZERO  = 2;
   localparam int QUOT_POS_1 = 3;
   localparam int QUOT_POS_2 = 4;

   localparam logic [QUOT_ONEHOT_WIDTH-1:0] DIGIT_NEG_2 = QUOT_ONEHOT_WIDTH'(1) << QUOT_NEG_2;
   localparam logic [QUOT_ONEHOT_WIDTH-1:0] DIGIT_NEG_1 = QUOT_ONEHOT_WIDTH'(1) << QUOT_NEG_1;
   localparam logic [QUOT_ONEHOT_WIDTH-1:0] DIGIT_ZERO  = QUOT_ONEHOT_WIDTH'(1) << QUOT_ZERO;
   localparam logic [QUOT_ONEHOT_WIDTH-1:0] DIGIT_POS_1 = QUOT_ONEHOT_WIDTH'(1) << QUOT_POS_1;
   localparam logic [QUOT_ONEHOT_WIDTH-1:0] DIGIT_POS_2 = QUOT_ONEHOT_WIDTH'(1) << QUOT_POS_2;

   typedef enum logic [1:0] {
      OTF_IDLE      = 2'd0,
      OTF_BUSY      = 2'd1,
      OTF_WAIT_SIGN = 2'd2,
      OTF_DONE      = 2'd3
   } otf_state_e;

endpackage

// File: rtl/radix_4_otf_step.sv
// rtl/radix_4_otf_step.sv - combinational Q/QM update for one radix-4 quotient digit
//
// Purpose: given the current Q/QM pair and a one-hot digit, produce the next pair
//          using only shifts and constant low bits (no carry-propagate adder).
// Ports:
//   q, qm            current quotient and quotient-minus-one
//   digit            one-hot digit (bit0=-2 .. bit4=+2)
//   q_next, qm_next  updated pair; equal to q/qm when the digit is not one-hot
//   illegal          digit is zero or multi-hot

module radix_4_otf_step
   import radix_4_div_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic [WIDTH-1:0]             q,
   input  logic [WIDTH-1:0]             qm,
   input  logic [QUOT_ONEHOT_WIDTH-1:0] digit,
   output logic [WIDTH-1:0]             q_next,
   output logic [WIDTH-1:0]             qm_next,
   output logic                         illegal
);

   // After a 2-bit left shift the low two bits are zero, so "+k" is a concatenation.
   always_comb begin
      q_next  = q;
      qm_next = qm;
      illegal = 1'b0;
      case (digit)
         DIGIT_POS_2: begin
            q_next  = {q[WIDTH-3:0], 2'b10};
            qm_next = {q[WIDTH-3:0], 2'b01};
         end
         DIGIT_POS_1: begin
            q_next  = {q[WIDTH-3:0], 2'b01};
            qm_next = {q[WIDTH-3:0], 2'b00};
         end
         DIGIT_ZERO: begin
            q_next  = {q[WIDTH-3:0], 2'b00};
            qm_next = {qm[WIDTH-3:0], 2'b11};
         end
         DIGIT_NEG_1: begin
            q_next  = {qm[WIDTH-3:0], 2'b11};
            qm_next = {qm[WIDTH-3:0], 2'b10};
         end
         DIGIT_NEG_2: begin
            q_next  = {qm[WIDTH-3:0], 2'b10};
            qm_next = {qm[WIDTH-3:0], 2'b01};
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/radix_4_otf_quot_converter.sv
// rtl/radix_4_otf_quot_converter.sv - radix-4 SRT on-the-fly quotient converter
//
// Purpose: accumulates redundant radix-4 quotient digits into the Q/QM pair,
//          applies the final remainder sign correction and hands out the binary
//          quotient over a valid/ready handshake.
// Optional: RADIX_4_OTF_ONEHOT_CHECK_EN adds the sticky err_o illegal-digit flag.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   kill_i                           synchronous abort back to IDLE
//   start_valid_i/start_ready_o      start handshake, iter_num_i sampled on accept
//   digit_valid_i/digit_ready_o      digit handshake for quot_digit_i
//   rem_sign_valid_i, rem_neg_i      final remainder sign
//   quot_valid_o/quot_ready_i        result handshake for quot_o
//   err_o                            (optional) sticky non-one-hot digit flag

module radix_4_otf_quot_converter #(
   parameter int WIDTH             = 32,
   parameter int QUOT_ONEHOT_WIDTH = radix_4_div_pkg::QUOT_ONEHOT_WIDTH,
   parameter int MAX_ITER          = WIDTH / 2,
   parameter int ITER_W            = $clog2(MAX_ITER + 1)
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         kill_i,
   input  logic                         start_valid_i,
   output logic                         start_ready_o,
   input  logic [ITER_W-1:0]            iter_num_i,
   input  logic                         digit_valid_i,
   output logic                         digit_ready_o,
   input  logic [QUOT_ONEHOT_WIDTH-1:0] quot_digit_i,
   input  logic                         rem_sign_valid_i,
   input  logic                         rem_neg_i,
   output logic                         quot_valid_o,
   input  logic                         quot_ready_i,
   output logic [WIDTH-1:0]             quot_o
`ifdef RADIX_4_OTF_ONEHOT_CHECK_EN
   ,
   output logic                         err_o
`endif
);

   import radix_4_div_pkg::*;

   otf_state_e        state, state_next;
   logic [WIDTH-1:0]  q, qm, q_next, qm_next;
   logic [ITER_W-1:0] cnt, n_iter;
   logic              illegal;
   logic              start_acc, digit_acc, sign_acc;

   radix_4_otf_step #(.WIDTH(WIDTH)) u_step (
      .q       (q),
      .qm      (qm),
      .digit   (quot_digit_i),
      .q_next  (q_next),
      .qm_next (qm_next),
      .illegal (illegal)
   );

   // Accepting from DONE while the result is consumed lets operations run back to back.
   assign start_ready_o = (state == OTF_IDLE) || ((state == OTF_DONE) && quot_ready_i);
   assign digit_ready_o = (state == OTF_BUSY);
   assign quot_valid_o  = (state == OTF_DONE);

   assign start_acc = start_valid_i && start_ready_o && !kill_i;
   assign digit_acc = digit_valid_i && (state == OTF_BUSY) && !kill_i;
   assign sign_acc  = rem_sign_valid_i && (state == OTF_WAIT_SIGN) && !kill_i;

   assign n_iter = (iter_num_i > ITER_W'(MAX_ITER)) ? ITER_W'(MAX_ITER) : iter_num_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= OTF_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (kill_i) begin
         state_next = OTF_IDLE;
      end else if (start_acc) begin
         state_next = (n_iter == '0) ? OTF_WAIT_SIGN : OTF_BUSY;
      end else begin
         case (state)
            OTF_BUSY:      if (digit_acc && (cnt == '0)) state_next = OTF_WAIT_SIGN;
            OTF_WAIT_SIGN: if (sign_acc) state_next = OTF_DONE;
            OTF_DONE:      if (quot_ready_i) state_next = OTF_IDLE;
            default:       state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q      <= '0;
         qm     <= '1;
         cnt    <= '0;
         quot_o <= '0;
      end else begin
         if (kill_i) begin
            q   <= '0;
            qm  <= '1;
            cnt <= '0;
         end else if (start_acc) begin
            q   <= '0;
            qm  <= '1;
            cnt <= (n_iter == '0) ? '0 : n_iter - ITER_W'(1);
         end else if (digit_acc) begin
            q   <= q_next;
            qm  <= qm_next;
            cnt <= cnt - ITER_W'(1);
         end
         // A negative final remainder means the quotient overshot by one.
         if (sign_acc) quot_o <= rem_neg_i ? qm : q;
      end
   end

`ifdef RADIX_4_OTF_ONEHOT_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      err_o <= 1'b0;
      else if (kill_i || start_acc)    err_o <= 1'b0;
      else if (digit_acc && illegal)   err_o <= 1'b1;
   end
`else
   logic unused_illegal;
   assign unused_illegal = illegal;
`endif

endmodule
